// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential restoring divider: FSM state encoding.
package seq_divider_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    SIGN = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract iteration: shift in the next dividend bit,
// try to subtract the divisor, keep the result only if it stayed non-negative.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The partial remainder is always below the divisor, so its top bit is
  // never needed when shifting.
  logic unused_rem_msb;
  assign unused_rem_msb = rem[WIDTH];

  assign shifted  = {rem[WIDTH-1:0], q[WIDTH-1]};
  assign trial    = shifted - {1'b0, divisor};
  assign rem_next = trial[WIDTH] ? shifted : trial;
  assign q_next   = {q[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/ready handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (adds a SIGN fix-up cycle).
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             done,
  output logic             div_by_zero
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH:0]   rem_reg, rem_next;
  logic [WIDTH-1:0] dvs_reg, dvs_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] quotient_next, remainder_next;
  logic             done_next, div_by_zero_next;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             neg_q_reg, neg_q_next;
  logic             neg_r_reg, neg_r_next;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .q        (q_reg),
    .divisor  (dvs_reg),
    .rem_next (step_rem),
    .q_next   (step_q)
  );

  assign ready = (state_reg == IDLE) & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      q_reg       <= '0;
      rem_reg     <= '0;
      dvs_reg     <= '0;
      cnt_reg     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      q_reg       <= q_next;
      rem_reg     <= rem_next;
      dvs_reg     <= dvs_next;
      cnt_reg     <= cnt_next;
      quotient    <= quotient_next;
      remainder   <= remainder_next;
      done        <= done_next;
      div_by_zero <= div_by_zero_next;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_reg   <= neg_q_next;
      neg_r_reg   <= neg_r_next;
`endif
    end
  end

  always_comb begin
    state_next       = state_reg;
    q_next           = q_reg;
    rem_next         = rem_reg;
    dvs_next         = dvs_reg;
    cnt_next         = cnt_reg;
    quotient_next    = quotient;
    remainder_next   = remainder;
    done_next        = 1'b0;
    div_by_zero_next = div_by_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_q_next       = neg_q_reg;
    neg_r_next       = neg_r_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // Divide-by-zero resolves on the accepting edge without iterating.
            quotient_next    = '1;
            remainder_next   = dividend;
            div_by_zero_next = 1'b1;
            done_next        = 1'b1;
          end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_next     = dividend[WIDTH-1] ? -dividend : dividend;
            dvs_next   = divisor[WIDTH-1] ? -divisor : divisor;
            neg_q_next = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_next = dividend[WIDTH-1];
`else
            q_next     = dividend;
            dvs_next   = divisor;
`endif
            rem_next   = '0;
            cnt_next   = CNT_W'(WIDTH);
            state_next = BUSY;
          end
        end
      end

      BUSY: begin
        q_next   = step_q;
        rem_next = step_rem;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          state_next = SIGN;
`else
          quotient_next    = step_q;
          remainder_next   = step_rem[WIDTH-1:0];
          div_by_zero_next = 1'b0;
          done_next        = 1'b1;
          state_next       = IDLE;
`endif
        end
      end

`ifdef SEQ_DIVIDER_SIGNED_EN
      SIGN: begin
        // Truncation toward zero: remainder takes the dividend's sign.
        quotient_next    = neg_q_reg ? -q_reg : q_reg;
        remainder_next   = neg_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
        div_by_zero_next = 1'b0;
        done_next        = 1'b1;
        state_next       = IDLE;
      end
`endif

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=4): directed vectors, monitor checks on done.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         ready;
  logic         done;
  logic         div_by_zero;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    int           start_cyc;
    string        name;
  } exp_t;

  exp_t sb[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .ready       (ready),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got=done at cycle %0d expected=no done", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".quotient"}, int'(quotient), int'(e.q));
        check({e.name, ".remainder"}, int'(remainder), int'(e.r));
        check({e.name, ".div_by_zero"}, int'(div_by_zero), int'(e.dz));
        check({e.name, ".latency"}, cyc - e.start_cyc, e.lat);
        check({e.name, ".ready_at_done"}, int'(ready), 1);
        $display("txn %s: q=%0h r=%0h dz=%0d latency=%0d", e.name, quotient, remainder,
                 div_by_zero, cyc - e.start_cyc);
      end
    end
  end

  // Drive start for one cycle from a negedge; optionally record the expectation.
  task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                       input int elat, input bit expect_done);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) check({name, ".ready_timeout"}, 0, 1);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (expect_done) begin
      e.q = eq; e.r = er; e.dz = edz; e.lat = elat; e.start_cyc = cyc; e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check({name, ".drain_timeout"}, sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    int lowcnt;
    int donecnt;

    repeat (2) @(negedge clk);
    check("reset.quotient", int'(quotient), 0);
    check("reset.remainder", int'(remainder), 0);
    check("reset.done", int'(done), 0);
    check("reset.div_by_zero", int'(div_by_zero), 0);
    check("reset.ready_in_reset", int'(ready), 0);
    reset = 1'b0;
    @(negedge clk);
    check("reset.ready_after", int'(ready), 1);

`ifdef SEQ_DIVIDER_SIGNED_EN
    issue("m7_div_2", 4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 6, 1'b1);
    drain("m7_div_2");
    issue("m8_div_m1", 4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 6, 1'b1);
    drain("m8_div_m1");
    issue("7_div_m2", 4'h7, 4'hE, 4'hD, 4'h1, 1'b0, 6, 1'b1);
    drain("7_div_m2");
    issue("m5_div_0", 4'hB, 4'h0, 4'hF, 4'hB, 1'b1, 1, 1'b1);
    drain("m5_div_0");
    issue("6_div_3", 4'h6, 4'h3, 4'h2, 4'h0, 1'b0, 6, 1'b1);
    drain("6_div_3");
`else
    // 13/3 with busy-window measurement.
    issue("13_div_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5, 1'b1);
    lowcnt = (ready == 1'b0) ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (!ready) lowcnt++;
    end
    check("13_div_3.ready_low_cycles", lowcnt, 4);
    drain("13_div_3");

    issue("7_div_9", 4'd7, 4'd9, 4'd0, 4'd7, 1'b0, 5, 1'b1);
    drain("7_div_9");
    issue("15_div_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5, 1'b1);
    drain("15_div_1");
    issue("5_div_0", 4'd5, 4'd0, 4'hF, 4'd5, 1'b1, 1, 1'b1);
    drain("5_div_0");
    issue("9_div_2", 4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 5, 1'b1);
    drain("9_div_2");

    // Reset two cycles after acceptance aborts the division.
    issue("abort", 4'd13, 4'd3, 4'd0, 4'd0, 1'b0, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort.quotient", int'(quotient), 0);
    check("abort.remainder", int'(remainder), 0);
    check("abort.done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort.ready_after", int'(ready), 1);
    donecnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) donecnt++;
    end
    check("abort.no_done", donecnt, 0);
    issue("13_div_3_again", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5, 1'b1);
    drain("13_div_3_again");

    // Start during BUSY is ignored; start in the done cycle is accepted.
    issue("13_div_3_busy", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5, 1'b1);
    start = 1'b1; dividend = 4'd6; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    donecnt = 0;
    while (!done && donecnt < 20) begin
      @(negedge clk);
      donecnt++;
    end
    check("b2b.done_seen", int'(done), 1);
    begin
      exp_t e;
      e.q = 4'd3; e.r = 4'd0; e.dz = 1'b0; e.lat = 5; e.start_cyc = cyc; e.name = "6_div_2_b2b";
      sb.push_back(e);
    end
    start = 1'b1; dividend = 4'd6; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    check("b2b.done_deasserts", int'(done), 0);
    drain("6_div_2_b2b");
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
